uart_tx: RTL

- Serial UART transmitter: the outbound end of the ALU/UART link.
- Accepts one SIZEDATA-bit word (normally the ALU result latched by the operand-collector interface).
- Serialises the word as 8N1 (start, data LSB-first, stop) on o_tx, timed by an external oversampling baud tick.
- Mirrors the existing receiver's framing and tick scheme, so RX and TX share one baud generator.

---
 rtl/uart_tx_pkg.sv | 27 ++
 rtl/uart_tx_if.sv | 38 +++
 rtl/uart_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared UART definitions: default frame/oversample parameters
//                and the one-hot transmitter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    // Default link parameters, shared by the receiver and the baud generator
    localparam int DEF_SIZEDATA   = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_SB_TICK    = 16;

    // One-hot transmitter states
    localparam logic [3:0] TX_IDLE  = 4'b0001;
    localparam logic [3:0] TX_START = 4'b0010;
    localparam logic [3:0] TX_DATA  = 4'b0100;
    localparam logic [3:0] TX_STOP  = 4'b1000;

    // Larger of two integers, used to size the shared tick counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_if
//  Description : Handshake/serial bundle between a word source and the UART
//                transmitter. The slave modport is the transmitter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if
    import uart_tx_pkg::*;
#(
    parameter int SIZEDATA = DEF_SIZEDATA
);
    logic                i_tick;
    logic                i_tx_start;
    logic [SIZEDATA-1:0] i_tx_data;
    logic                o_tx;
    logic                o_tx_busy;
    logic                o_tx_done;

    modport slave (
        input  i_tick,
        input  i_tx_start,
        input  i_tx_data,
        output o_tx,
        output o_tx_busy,
        output o_tx_done
    );

    modport master (
        output i_tick,
        output i_tx_start,
        output i_tx_data,
        input  o_tx,
        input  o_tx_busy,
        input  o_tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1-style UART transmitter driven by an external oversampling
//                baud tick. Start bit, SIZEDATA data bits LSB first, stop bit
//                lasting SB_TICK ticks. Line output is registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int SIZEDATA   = DEF_SIZEDATA,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int SB_TICK    = DEF_SB_TICK
)(
    input  wire      i_clock,
    input  wire      i_reset,
    uart_tx_if.slave bus
);

    localparam int SW_RAW = $clog2(max_int(OVERSAMPLE, SB_TICK));
    localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;
    localparam int NW_RAW = $clog2(SIZEDATA);
    localparam int NW     = (NW_RAW < 1) ? 1 : NW_RAW;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(SIZEDATA - 1);

    logic [3:0]          state_q, state_d;
    logic [SW-1:0]       s_q,     s_d;
    logic [NW-1:0]       n_q,     n_d;
    logic [SIZEDATA-1:0] shreg_q, shreg_d;
    logic                tx_q,    tx_d;
    logic                done_q,  done_d;

    // Next-state, counter, shift register and line-level decode
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (bus.i_tx_start) begin
                    shreg_d = bus.i_tx_data;
                    s_d     = '0;
                    state_d = TX_START;
                    tx_d    = 1'b0;
                end
            end

            TX_START: begin
                if (bus.i_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = TX_DATA;
                        tx_d    = shreg_q[0];
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            TX_DATA: begin
                if (bus.i_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        shreg_d = shreg_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = TX_STOP;
                            tx_d    = 1'b1;
                        end else begin
                            n_d  = n_q + 1'b1;
                            // Bit 1 becomes the LSB once the register shifts
                            tx_d = shreg_q[1];
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            TX_STOP: begin
                if (bus.i_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        s_d     = '0;
                        state_d = TX_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            default: begin
                // Corrupted one-hot code: fall back to a quiet idle line
                state_d = TX_IDLE;
                s_d     = '0;
                n_d     = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial frame at once
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= TX_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Busy comes straight from the IDLE flop of the one-hot code, so it is
    // a single register bit and cannot glitch.
    assign bus.o_tx      = tx_q;
    assign bus.o_tx_busy = ~state_q[0];
    assign bus.o_tx_done = done_q;

endmodule
`default_nettype wire
